// File: rtl/fproc_meas_responder_if.sv
// Purpose: bundles the measurement inputs and the per-core fproc request/response
//          signals of fproc_meas_responder into one port.
// Ports:   master = measurement source plus the core controllers; slave = the responder.
interface fproc_meas_responder_if #(
  parameter int N_CORES    = 2,
  parameter int N_MEAS     = 2,
  parameter int MEAS_WIDTH = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  logic [N_MEAS*MEAS_WIDTH-1:0] meas;
  logic [N_MEAS-1:0]            meas_valid;
  logic [N_CORES-1:0]           fproc_req;
  logic [N_CORES*ID_WIDTH-1:0]  fproc_id;
  logic [N_CORES-1:0]           fproc_ready;
  logic [N_CORES*DATA_WIDTH-1:0] fproc_data;

  modport master (
    output meas, meas_valid, fproc_req, fproc_id,
    input  fproc_ready, fproc_data
  );

  modport slave (
    input  meas, meas_valid, fproc_req, fproc_id,
    output fproc_ready, fproc_data
  );
endinterface

// File: rtl/fproc_meas_responder.sv
// Purpose: keeps the latest result per readout channel and answers each core's fproc
//          request once fresh data exists for the requested channel.
// Latency: ready two cycles after a request that finds fresh data, or two cycles
//          after meas_valid for a waiting core; ids >= N_MEAS answer 0 after two cycles.
// Backpressure: none; a request arriving while a core is busy is dropped.
// Ports: clk, reset (sync, active-low), bus (slave modport of fproc_meas_responder_if).
// Optional: define FPROC_TIMEOUT_EN to give each waiting core a TIMEOUT_CYCLES limit,
//           after which it answers with all ones.
module fproc_meas_responder #(
  parameter int N_CORES        = 2,
  parameter int N_MEAS         = 2,
  parameter int MEAS_WIDTH     = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   reset,
  fproc_meas_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [MEAS_WIDTH-1:0] result [N_MEAS];
  logic [N_MEAS-1:0]     fresh;
  logic [N_MEAS-1:0]     consume;
  // Channel one-hot of each core while it sits in WAIT, zero otherwise.
  logic [N_MEAS-1:0]     wait_sel [N_CORES];

  // A waiting core consumes a channel only when fresh is set for it.
  always_comb begin
    consume = '0;
    for (int c = 0; c < N_CORES; c++) begin
      consume = consume | wait_sel[c];
    end
    consume = consume & fresh;
  end

  // Set has priority over consume: a new result keeps the channel fresh.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fresh <= '0;
      for (int k = 0; k < N_MEAS; k++) begin
        result[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_MEAS; k++) begin
        if (bus.meas_valid[k]) begin
          result[k] <= bus.meas[k*MEAS_WIDTH +: MEAS_WIDTH];
          fresh[k]  <= 1'b1;
        end else if (consume[k]) begin
          fresh[k]  <= 1'b0;
        end
      end
    end
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    state_t                state;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  ready_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  id_ok;
    logic                  sel_fresh;
    logic [MEAS_WIDTH-1:0] sel_res;
    logic [N_MEAS-1:0]     sel_onehot;

    // Decode the latched id by comparison so that out-of-range ids never index storage.
    always_comb begin
      id_ok      = 1'b0;
      sel_fresh  = 1'b0;
      sel_res    = '0;
      sel_onehot = '0;
      for (int k = 0; k < N_MEAS; k++) begin
        if (id_q == ID_WIDTH'(k)) begin
          id_ok         = 1'b1;
          sel_fresh     = fresh[k];
          sel_res       = result[k];
          sel_onehot[k] = 1'b1;
        end
      end
    end

    assign wait_sel[c] = (state == WAIT) ? sel_onehot : '0;
    assign bus.fproc_ready[c] = ready_r;
    assign bus.fproc_data[c*DATA_WIDTH +: DATA_WIDTH] = data_r;

`ifdef FPROC_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt;
`endif

    // Every request passes through WAIT so that in-range and out-of-range ids
    // share the same two-cycle response schedule. The ready/data registers are
    // loaded on the edge that enters RESP, so they are high exactly while in RESP.
    always_ff @(posedge clk) begin
      if (!reset) begin
        state   <= IDLE;
        id_q    <= '0;
        ready_r <= 1'b0;
        data_r  <= '0;
`ifdef FPROC_TIMEOUT_EN
        wait_cnt <= '0;
`endif
      end else begin
        ready_r <= 1'b0;
        data_r  <= '0;
        case (state)
          IDLE: begin
            if (bus.fproc_req[c]) begin
              id_q  <= bus.fproc_id[c*ID_WIDTH +: ID_WIDTH];
              state <= WAIT;
`ifdef FPROC_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end
          end
          WAIT: begin
            if (!id_ok) begin
              state   <= RESP;
              ready_r <= 1'b1;
            end else if (sel_fresh) begin
              state   <= RESP;
              ready_r <= 1'b1;
              data_r  <= DATA_WIDTH'(sel_res);
            end
`ifdef FPROC_TIMEOUT_EN
            else if (wait_cnt == TMO) begin
              state   <= RESP;
              ready_r <= 1'b1;
              data_r  <= '1;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
`endif
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fproc_meas_responder.sv
// Purpose: directed checks of fproc_meas_responder: reset, hit/miss latency, shared
//          consumption, set-wins, out-of-range id, reset mid-wait, optional timeout.
// Ports: none; drives the DUT through an fproc_meas_responder_if instance.
module tb_fproc_meas_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

`ifdef FPROC_TIMEOUT_EN
  localparam int LONG_WAIT = 5;
`else
  localparam int LONG_WAIT = 10;
`endif

  fproc_meas_responder_if bus ();

  fproc_meas_responder #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int c);
    return bus.fproc_data[c*32 +: 32];
  endfunction

  // Request strobe for one cycle; returns in the cycle after the request.
  task automatic pulse_req(input logic [1:0] m, input logic [7:0] i0, input logic [7:0] i1);
    bus.fproc_req = m;
    bus.fproc_id  = {i1, i0};
    tick();
    bus.fproc_req = 2'b00;
  endtask

  // Measurement strobe for one cycle; returns in the cycle after the strobe.
  task automatic pulse_meas(input logic [1:0] m, input logic [1:0] v);
    bus.meas_valid = m;
    bus.meas       = v;
    tick();
    bus.meas_valid = 2'b00;
  endtask

  // Run n cycles and require that no ready pulse appears on any core.
  task automatic idle_for(input int n, input string tag);
    logic [1:0] seen;
    seen = 2'b00;
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | bus.fproc_ready;
    end
    chk(tag, 64'(seen), 64'h0);
  endtask

  initial begin
    bus.meas       = '0;
    bus.meas_valid = '0;
    bus.fproc_req  = '0;
    bus.fproc_id   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 64'(bus.fproc_ready), 64'h0);
    chk("rst_data",  64'(bus.fproc_data),  64'h0);
    reset = 1'b1;

    // Hit: data present before the request
    pulse_meas(2'b01, 2'b01);
    pulse_req(2'b01, 8'd0, 8'd0);
    tick();
    chk("hit_ready", 64'(bus.fproc_ready), 64'h1);
    chk("hit_data0", 64'(dat(0)), 64'h1);
    tick();
    chk("hit_ready_drop", 64'(bus.fproc_ready), 64'h0);
    chk("hit_data_drop",  64'(dat(0)), 64'h0);

    // fresh[0] was consumed: a new request waits until the next strobe
    pulse_req(2'b01, 8'd0, 8'd0);
    idle_for(5, "consumed_wait");
    pulse_meas(2'b01, 2'b01);
    tick();
    chk("refill_ready", 64'(bus.fproc_ready), 64'h1);
    chk("refill_data0", 64'(dat(0)), 64'h1);
    tick();

    // Miss: core 1 waits on channel 1, core 0 stays idle
    pulse_req(2'b10, 8'd0, 8'd1);
    idle_for(LONG_WAIT, "miss_wait");
    pulse_meas(2'b10, 2'b10);
    tick();
    chk("miss_ready", 64'(bus.fproc_ready), 64'h2);
    chk("miss_data1", 64'(dat(1)), 64'h1);
    chk("miss_data0", 64'(dat(0)), 64'h0);
    tick();

    // Both cores wait on channel 0 and share one result
    pulse_req(2'b11, 8'd0, 8'd0);
    idle_for(3, "both_wait");
    pulse_meas(2'b01, 2'b01);
    tick();
    chk("both_ready", 64'(bus.fproc_ready), 64'h3);
    chk("both_data0", 64'(dat(0)), 64'h1);
    chk("both_data1", 64'(dat(1)), 64'h1);
    tick();
    pulse_req(2'b01, 8'd0, 8'd0);
    idle_for(4, "after_both_wait");
    pulse_meas(2'b01, 2'b01);
    tick();
    chk("after_both_ready", 64'(bus.fproc_ready), 64'h1);
    tick();

    // Consume and new strobe in the same cycle: old value out, channel stays fresh
    pulse_meas(2'b01, 2'b01);
    tick();
    pulse_req(2'b01, 8'd0, 8'd0);
    pulse_meas(2'b01, 2'b00);
    chk("setwin_ready", 64'(bus.fproc_ready), 64'h1);
    chk("setwin_data0", 64'(dat(0)), 64'h1);
    tick();
    pulse_req(2'b10, 8'd0, 8'd0);
    tick();
    chk("setwin_next_ready", 64'(bus.fproc_ready), 64'h2);
    chk("setwin_next_data1", 64'(dat(1)), 64'h0);
    tick();

    // Out-of-range id answers 0 after two cycles
    pulse_meas(2'b01, 2'b01);
    tick();
    pulse_req(2'b01, 8'd5, 8'd0);
    tick();
    chk("badid_ready", 64'(bus.fproc_ready), 64'h1);
    chk("badid_data0", 64'(dat(0)), 64'h0);
    tick();
    chk("badid_drop", 64'(bus.fproc_ready), 64'h0);

    // Request while waiting is ignored; reset abandons the wait; fresh survives
    pulse_req(2'b01, 8'd1, 8'd0);
    tick();
    pulse_req(2'b01, 8'd5, 8'd0);
    idle_for(3, "busy_req_ignored");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pulse_meas(2'b10, 2'b10);
    idle_for(5, "reset_abandon");
    pulse_req(2'b01, 8'd1, 8'd0);
    tick();
    chk("post_rst_ready", 64'(bus.fproc_ready), 64'h1);
    chk("post_rst_data0", 64'(dat(0)), 64'h1);
    tick();

`ifdef FPROC_TIMEOUT_EN
    begin
      int n;
      // Channel 0 was refreshed then reset cleared it; wait with no data.
      pulse_req(2'b01, 8'd0, 8'd0);
      n = 0;
      while (!bus.fproc_ready[0] && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_ready", 64'(bus.fproc_ready[0]), 64'h1);
      chk("tmo_cycles", 64'(n), 64'd9);
      chk("tmo_data0", 64'(dat(0)), 64'hFFFF_FFFF);
      tick();
      pulse_meas(2'b01, 2'b01);
      pulse_req(2'b01, 8'd0, 8'd0);
      tick();
      chk("tmo_after_ready", 64'(bus.fproc_ready), 64'h1);
      chk("tmo_after_data0", 64'(dat(0)), 64'h1);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
